// File: rtl/fuzzy_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module     : fuzzy_seq_ctrl_if
//  Description: Request/sample/grant bundle of the fuzzification sequencer
//               plus its pipeline-facing outputs. out_ready exists only when
//               FUZZY_SEQ_STALL_EN is defined.
//  Revision   : 1.0 - initial release
// ============================================================================
interface fuzzy_seq_ctrl_if #(
   parameter int W = 8
);
   logic          req_a;
   logic [W-1:0]  in1_a;
   logic [W-1:0]  in2_a;
   logic          gnt_a;
   logic          req_b;
   logic [W-1:0]  in1_b;
   logic [W-1:0]  in2_b;
   logic          gnt_b;
   logic [W-1:0]  Input_01;
   logic [W-1:0]  Input_02;
   logic          EN_SCLK;
   logic          busy;
   logic          out_valid;
   logic          out_tag;
`ifdef FUZZY_SEQ_STALL_EN
   logic          out_ready;
`endif

   // Requesters and result consumer
   modport master (
      output req_a, in1_a, in2_a, req_b, in1_b, in2_b,
`ifdef FUZZY_SEQ_STALL_EN
      output out_ready,
`endif
      input  gnt_a, gnt_b, Input_01, Input_02, EN_SCLK, busy, out_valid, out_tag
   );

   // Sequencer side
   modport slave (
      input  req_a, in1_a, in2_a, req_b, in1_b, in2_b,
`ifdef FUZZY_SEQ_STALL_EN
      input  out_ready,
`endif
      output gnt_a, gnt_b, Input_01, Input_02, EN_SCLK, busy, out_valid, out_tag
   );
endinterface
`default_nettype wire

// File: rtl/fuzzy_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module     : fuzzy_seq_ctrl
//  Description: Round-robin two-source arbiter and EN_SCLK sequencer for the
//               type-2 fuzzification pipeline. One sample in flight at a
//               time: IDLE (grant + load) -> RUN (PIPE_LAT strobes every DIV
//               clocks) -> DONE (result valid, tagged with source).
//               Optional macro FUZZY_SEQ_STALL_EN: DONE waits for out_ready.
//  Revision   : 1.0 - initial release
// ============================================================================
module fuzzy_seq_ctrl #(
   parameter int PIPE_LAT = 3,
   parameter int DIV      = 4,
   parameter int W        = 8
) (
   input  wire logic          clk,
   input  wire logic          RESET,
   fuzzy_seq_ctrl_if.slave    sif
);

   localparam int c_div_w = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int c_stb_w = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
   localparam logic [c_div_w-1:0] c_div_last = c_div_w'(DIV - 1);
   localparam logic [c_stb_w-1:0] c_stb_last = c_stb_w'(PIPE_LAT - 1);

   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_run  = 2'd1;
   localparam logic [1:0] c_st_done = 2'd2;

   logic [1:0]          r_state;
   logic                r_ptr;       // 1: B holds priority on a tie
   logic [W-1:0]        r_in1;
   logic [W-1:0]        r_in2;
   logic                r_tag;       // source of the sample in flight
   logic                r_out_tag;   // source of the last completed result
   logic [c_div_w-1:0]  r_div_cnt;
   logic [c_stb_w-1:0]  r_stb_cnt;

   logic w_idle;
   logic w_any;
   logic w_sel_b;
   logic w_gnt_a;
   logic w_gnt_b;
   logic w_strobe;
   logic w_last;
   logic w_done_exit;

   // Arbitration, strobe generation and DONE release
   always_comb begin
      w_idle   = (r_state == c_st_idle);
      w_any    = sif.req_a | sif.req_b;
      w_sel_b  = sif.req_b & (~sif.req_a | r_ptr);
      // grants are Mealy on the requests; masked while reset is asserted
      w_gnt_a  = w_idle & RESET & w_any & ~w_sel_b;
      w_gnt_b  = w_idle & RESET & w_any &  w_sel_b;
      w_strobe = (r_state == c_st_run) && (r_div_cnt == c_div_last);
      w_last   = w_strobe && (r_stb_cnt == c_stb_last);
`ifdef FUZZY_SEQ_STALL_EN
      w_done_exit = sif.out_ready;
`else
      w_done_exit = 1'b1;
`endif
   end

   // Sequencer state, sample load, counters and tags
   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         r_state   <= c_st_idle;
         r_ptr     <= 1'b0;
         r_in1     <= '0;
         r_in2     <= '0;
         r_tag     <= 1'b0;
         r_out_tag <= 1'b0;
         r_div_cnt <= '0;
         r_stb_cnt <= '0;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (w_any) begin
                  r_state   <= c_st_run;
                  r_ptr     <= ~w_sel_b;
                  r_in1     <= w_sel_b ? sif.in1_b : sif.in1_a;
                  r_in2     <= w_sel_b ? sif.in2_b : sif.in2_a;
                  r_tag     <= w_sel_b;
                  r_div_cnt <= '0;
                  r_stb_cnt <= '0;
               end
            end
            c_st_run: begin
               if (w_strobe) begin
                  r_div_cnt <= '0;
                  if (w_last) begin
                     r_state   <= c_st_done;
                     r_out_tag <= r_tag;
                  end else begin
                     r_stb_cnt <= r_stb_cnt + 1'b1;
                  end
               end else begin
                  r_div_cnt <= r_div_cnt + 1'b1;
               end
            end
            c_st_done: begin
               if (w_done_exit) begin
                  r_state <= c_st_idle;
               end
            end
            default: r_state <= c_st_idle;
         endcase
      end
   end

   assign sif.gnt_a     = w_gnt_a;
   assign sif.gnt_b     = w_gnt_b;
   assign sif.Input_01  = r_in1;
   assign sif.Input_02  = r_in2;
   assign sif.EN_SCLK   = w_strobe;
   assign sif.busy      = ~w_idle;
   assign sif.out_valid = (r_state == c_st_done);
   assign sif.out_tag   = r_out_tag;

endmodule
`default_nettype wire
